// File: rtl/dbus_arbiter.sv
// dbus_arbiter
// Two-master, one-slave data-bus arbiter. Master 0 is the core data bus and
// master 1 is the debug/DMA master. One grant carries exactly one slave
// transaction. When both masters request in the same IDLE cycle, the grant
// alternates between them (round-robin), and master 0 wins first after reset.
// A slave that never acknowledges is cut off after TIMEOUT wait cycles. The
// granted master then gets an error completion.
//
// Ports
//   clk, rst_n                      clock (rising edge) and async active-low reset
//   m0_*/m1_*  req_i, addr_i,       master request (level), address, write data,
//              wdata_i, w_en_i      write enable (1 = write, 0 = read)
//   m0_*/m1_*  ack_o, rdata_o,      completion strobe, read data,
//              err_o                timeout flag (valid together with ack)
//   s_req_o, s_addr_o, s_wdata_o,   request and payload toward the peripheral bus
//   s_w_en_o
//   s_ack_i, s_rdata_i              slave acknowledge and read data
module dbus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic              m0_w_en_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic              m1_w_en_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_err_o,
  output logic              s_req_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  output logic              s_w_en_o,
  input  logic              s_ack_i,
  input  logic [DATA_W-1:0] s_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     r_state;
  state_t     w_nextState;
  logic       r_lastGnt;
  logic [7:0] r_waitCnt;
  logic       r_rstSync;
  logic       w_timeout;

  // This flop stays low for the first edge after reset is released. Holding the
  // FSM in IDLE for that edge makes the release synchronous to clk, so the
  // earliest grant happens on the second edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstSync <= 1'b0;
    end else begin
      r_rstSync <= 1'b1;
    end
  end

  // The timeout fires only when the slave stays silent in the cycle where the
  // counter reaches the limit. An ack in that same cycle still gives a normal
  // completion.
  assign w_timeout = (r_state != IDLE) && !s_ack_i && (r_waitCnt == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // r_lastGnt = 1 means master 1 was granted last, so master 0 wins the next
  // tie. Reset sets it to 1 so that master 0 is favoured first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastGnt <= 1'b1;
    end else if (r_state == IDLE && w_nextState == GNT0) begin
      r_lastGnt <= 1'b0;
    end else if (r_state == IDLE && w_nextState == GNT1) begin
      r_lastGnt <= 1'b1;
    end
  end

  // The counter is held at zero in IDLE, so every grant starts counting from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt <= 8'd0;
    end else if (r_state == IDLE) begin
      r_waitCnt <= 8'd0;
    end else if (!s_ack_i) begin
      r_waitCnt <= r_waitCnt + 8'd1;
    end
  end

  // Requests are level-sensitive and are only looked at in IDLE. Once a grant
  // is made, the FSM stays with it until ack or timeout, even if the owner
  // drops its request or the other master starts requesting.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (r_rstSync) begin
          if (m0_req_i && m1_req_i) begin
            w_nextState = r_lastGnt ? GNT0 : GNT1;
          end else if (m0_req_i) begin
            w_nextState = GNT0;
          end else if (m1_req_i) begin
            w_nextState = GNT1;
          end
        end
      end
      GNT0, GNT1: begin
        if (s_ack_i || w_timeout) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The payload mux and the completion path are purely combinational, driven
  // by the state. In IDLE every output is zero, so a stray slave ack reaches
  // nobody.
  always_comb begin
    s_req_o    = 1'b0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_w_en_o   = 1'b0;
    m0_ack_o   = 1'b0;
    m0_rdata_o = '0;
    m0_err_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m1_rdata_o = '0;
    m1_err_o   = 1'b0;
    case (r_state)
      GNT0: begin
        s_req_o    = 1'b1;
        s_addr_o   = m0_addr_i;
        s_wdata_o  = m0_wdata_i;
        s_w_en_o   = m0_w_en_i;
        m0_ack_o   = s_ack_i | w_timeout;
        m0_err_o   = w_timeout;
        m0_rdata_o = w_timeout ? '0 : s_rdata_i;
      end
      GNT1: begin
        s_req_o    = 1'b1;
        s_addr_o   = m1_addr_i;
        s_wdata_o  = m1_wdata_i;
        s_w_en_o   = m1_w_en_i;
        m1_ack_o   = s_ack_i | w_timeout;
        m1_err_o   = w_timeout;
        m1_rdata_o = w_timeout ? '0 : s_rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter
// Self-checking bench for dbus_arbiter, built with TIMEOUT = 4.
// The stimulus side decides which master should win each round, using the
// round-robin rule. It also decides when the slave acknowledges. From these it
// pushes the expected grant and completion into queues. A separate monitor pops
// those entries whenever the DUT raises s_req_o or a master ack, and compares.
module tb_dbus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    int          len;
  } gnt_t;

  typedef struct {
    int          m;
    logic        err;
    logic [31:0] rdata;
  } cpl_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    pend = 2'b00;
  logic [AW-1:0] pAddr [2];
  logic [DW-1:0] pWdata [2];
  logic          pWen [2];

  logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          s_req_o, s_w_en_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_wdata_o;
  logic          s_ack_i;
  logic [DW-1:0] s_rdata_i;

  int          checks = 0;
  int          errors = 0;
  gnt_t        gntQ[$];
  cpl_t        cplQ[$];
  int          lastWin = 1;
  int          slvDelay = 99;
  logic [31:0] slvData = '0;
  int          strayMode = 1;

  dbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req_i  (pend[0]),
    .m0_addr_i (pAddr[0]),
    .m0_wdata_i(pWdata[0]),
    .m0_w_en_i (pWen[0]),
    .m0_ack_o  (m0_ack_o),
    .m0_rdata_o(m0_rdata_o),
    .m0_err_o  (m0_err_o),
    .m1_req_i  (pend[1]),
    .m1_addr_i (pAddr[1]),
    .m1_wdata_i(pWdata[1]),
    .m1_w_en_i (pWen[1]),
    .m1_ack_o  (m1_ack_o),
    .m1_rdata_o(m1_rdata_o),
    .m1_err_o  (m1_err_o),
    .s_req_o   (s_req_o),
    .s_addr_o  (s_addr_o),
    .s_wdata_o (s_wdata_o),
    .s_w_en_o  (s_w_en_o),
    .s_ack_i   (s_ack_i),
    .s_rdata_i (s_rdata_i)
  );

  always #5 clk = ~clk;

  // Slave model. During a grant it acks in cycle slvDelay+1. Outside a grant
  // it pulses s_ack_i at random, or holds it high, so that stray acks get
  // exercised. Outside the ack cycle the read data is random noise.
  initial begin : slaveModel
    int grantCycle;
    grantCycle = 0;
    s_ack_i    = 1'b0;
    s_rdata_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (s_req_o) begin
        grantCycle++;
        s_ack_i   = (grantCycle == slvDelay + 1);
        s_rdata_i = s_ack_i ? slvData : $urandom();
      end else begin
        grantCycle = 0;
        s_ack_i    = (strayMode == 2) ? 1'b1 :
                     (strayMode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        s_rdata_i  = $urandom();
      end
    end
  end

  // Monitor state shared across negedges: the current grant owner, its
  // expected length (-1 = grant killed by reset, not checked), the cycles seen
  // so far, and s_req_o from the previous negedge.
  int curM = 0, curExpLen = -1, curLen = 0;
  logic prevReq = 1'b0;

  task automatic checkOutput();
    cpl_t c;
    gnt_t g;
    int   gotM;
    logic gotErr;
    logic [31:0] gotData;
    if (m0_ack_o || m1_ack_o) begin
      checks++;
      if (cplQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_ack got m0_ack=%0b m1_ack=%0b required none", m0_ack_o, m1_ack_o);
      end else begin
        c       = cplQ.pop_front();
        gotM    = m1_ack_o ? 1 : 0;
        gotErr  = gotM == 1 ? m1_err_o : m0_err_o;
        gotData = gotM == 1 ? m1_rdata_o : m0_rdata_o;
        if ((m0_ack_o && m1_ack_o) || gotM != c.m || gotErr != c.err || gotData != c.rdata) begin
          errors++;
          $display("[TB] FAIL completion got m=%0d(both=%0b) err=%0b rdata=%h required m=%0d err=%0b rdata=%h",
                   gotM, m0_ack_o && m1_ack_o, gotErr, gotData, c.m, c.err, c.rdata);
        end
      end
    end
    if (s_req_o && !prevReq) begin
      checks++;
      if (gntQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_grant got s_addr=%h required no grant", s_addr_o);
      end else begin
        g         = gntQ.pop_front();
        curM      = g.m;
        curExpLen = g.len;
        curLen    = 1;
        if (s_addr_o != g.addr || s_wdata_o != g.wdata || s_w_en_o != g.wen) begin
          errors++;
          $display("[TB] FAIL grant_payload got addr=%h wdata=%h wen=%0b required m%0d addr=%h wdata=%h wen=%0b",
                   s_addr_o, s_wdata_o, s_w_en_o, g.m, g.addr, g.wdata, g.wen);
        end
      end
    end else if (s_req_o) begin
      curLen++;
    end else if (prevReq && curExpLen >= 0) begin
      checks++;
      if (curLen != curExpLen) begin
        errors++;
        $display("[TB] FAIL grant_length got %0d cycles required %0d", curLen, curExpLen);
      end
    end
    if (!s_req_o) begin
      checks++;
      if (s_addr_o != '0 || s_wdata_o != '0 || s_w_en_o || m0_err_o || m1_err_o ||
          m0_rdata_o != '0 || m1_rdata_o != '0) begin
        errors++;
        $display("[TB] FAIL idle_outputs got addr=%h wdata=%h wen=%0b err=%0b%0b rd0=%h rd1=%h required all 0",
                 s_addr_o, s_wdata_o, s_w_en_o, m0_err_o, m1_err_o, m0_rdata_o, m1_rdata_o);
      end
    end else begin
      checks++;
      if ((curM == 0 && (m1_ack_o || m1_err_o || m1_rdata_o != '0)) ||
          (curM == 1 && (m0_ack_o || m0_err_o || m0_rdata_o != '0))) begin
        errors++;
        $display("[TB] FAIL ungranted_outputs got owner=m%0d m0 ack/err/rd=%0b/%0b/%h m1 ack/err/rd=%0b/%0b/%h required other master 0",
                 curM, m0_ack_o, m0_err_o, m0_rdata_o, m1_ack_o, m1_err_o, m1_rdata_o);
      end
    end
    prevReq = s_req_o;
  endtask

  // The monitor samples on every falling edge, away from the DUT's active edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      checkOutput();
    end
  end

  task automatic setRequest(input int m, input logic [31:0] addr, input logic [31:0] wdata, input logic wen);
    pAddr[m]  = addr;
    pWdata[m] = wdata;
    pWen[m]   = wen;
    pend[m]   = 1'b1;
  endtask

  // Reference model for one round. Among the pending masters the winner is the
  // single requester, or, on a tie, the master not granted last. The slave
  // acks in cycle d+1, but the grant is cut off after TO+1 cycles.
  task automatic expectRound(input int d, input logic [31:0] data, output int w);
    gnt_t g;
    cpl_t c;
    int   ackCyc;
    int   toCyc;
    if (pend[0] && pend[1]) w = 1 - lastWin;
    else                    w = pend[0] ? 0 : 1;
    lastWin = w;
    ackCyc  = d + 1;
    toCyc   = TO + 1;
    g.m     = w;
    g.addr  = pAddr[w];
    g.wdata = pWdata[w];
    g.wen   = pWen[w];
    g.len   = (ackCyc <= toCyc) ? ackCyc : toCyc;
    c.m     = w;
    c.err   = (ackCyc > toCyc);
    c.rdata = c.err ? 32'h0 : data;
    gntQ.push_back(g);
    cplQ.push_back(c);
    slvDelay = d;
    slvData  = data;
  endtask

  task automatic waitAck(input int w);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = (w == 0) ? m0_ack_o : m1_ack_o;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_wait got no ack from m%0d in 30 cycles required ack", w);
    end
    @(posedge clk);
    #1;
    pend[w] = 1'b0;
  endtask

  task automatic applyStimulus(input int d, input logic [31:0] data, output int w);
    expectRound(d, data, w);
    waitAck(w);
  endtask

  // Directed scenarios come first, then randomized rounds.
  initial begin : driver
    int w;
    bit seen;
    pAddr[0] = '0; pAddr[1] = '0; pWdata[0] = '0; pWdata[1] = '0; pWen[0] = 1'b0; pWen[1] = 1'b0;

    // Reset with both masters requesting: all outputs must be zero.
    rst_n = 1'b0;
    setRequest(0, 32'h0000_0100, 32'h1111_0000, 1'b0);
    setRequest(1, 32'h0000_0200, 32'hCAFE_0001, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (s_req_o || s_addr_o != '0 || s_wdata_o != '0 || s_w_en_o || m0_ack_o || m1_ack_o ||
        m0_err_o || m1_err_o || m0_rdata_o != '0 || m1_rdata_o != '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got s_req=%0b addr=%h ack=%0b%0b required all 0",
               s_req_o, s_addr_o, m0_ack_o, m1_ack_o);
    end
    #1;
    rst_n   = 1'b1;
    lastWin = 1;

    // Both masters request continuously and every ack takes one cycle:
    // the grants must alternate m0, m1, m0, m1.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, $urandom(), w);
      if (k < 3) begin
        if (w == 0) setRequest(0, 32'h0000_0100 + k, 32'h1111_0000 + k, 1'b0);
        else        setRequest(1, 32'h0000_0200 + k, 32'hCAFE_0010 + k, 1'b1);
      end
    end
    while (pend != 2'b00) applyStimulus(0, $urandom(), w);

    // m0 read at 0x10 with the slave acking after 3 wait cycles.
    setRequest(0, 32'h0000_0010, 32'h0, 1'b0);
    applyStimulus(3, 32'hDEAD_BEEF, w);

    // m1 with a slave that never acks: error completion in the 5th cycle.
    setRequest(1, 32'h0000_0300, 32'h5555_AAAA, 1'b0);
    applyStimulus(99, 32'h0, w);

    // An ack in exactly the timeout cycle wins: normal completion.
    setRequest(1, 32'h0000_0304, 32'h0, 1'b0);
    applyStimulus(4, 32'h1234_5678, w);

    // No grant while stray acks are driven: no master ack is allowed.
    strayMode = 2;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (m0_ack_o || m1_ack_o) begin
        errors++;
        $display("[TB] FAIL stray_ack got m0_ack=%0b m1_ack=%0b required 0", m0_ack_o, m1_ack_o);
      end
    end
    @(posedge clk);
    #1;
    strayMode = 1;

    // Reset in the 2nd GNT0 cycle; then both request and m0 must win first.
    setRequest(0, 32'h0000_0400, 32'h0, 1'b0);
    begin
      gnt_t g;
      g.m = 0; g.addr = pAddr[0]; g.wdata = pWdata[0]; g.wen = pWen[0]; g.len = -1;
      gntQ.push_back(g);
    end
    slvDelay = 99;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = s_req_o;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || s_req_o || m0_ack_o) begin
      errors++;
      $display("[TB] FAIL reset_mid_grant got granted=%0b s_req=%0b m0_ack=%0b required 1/0/0", seen, s_req_o, m0_ack_o);
    end
    pend    = 2'b00;
    lastWin = 1;
    setRequest(0, 32'h0000_0500, 32'h0, 1'b0);
    setRequest(1, 32'h0000_0600, 32'h7777_0000, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    expectRound(0, $urandom(), w);
    @(posedge clk);
    #1;
    checks++;
    if (s_req_o) begin
      errors++;
      $display("[TB] FAIL release_edge1 got s_req=%0b required 0", s_req_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (!s_req_o) begin
      errors++;
      $display("[TB] FAIL release_edge2 got s_req=%0b required 1", s_req_o);
    end
    waitAck(w);
    applyStimulus($urandom_range(0, 6), $urandom(), w);

    // Randomized rounds: random requesters, payloads and slave delays.
    for (int r = 0; r < 40; r++) begin
      if (pend == 2'b00) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(0, 1) == 1)
          setRequest(m, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
      if (pend == 2'b00) setRequest(int'($urandom_range(0, 1)), $urandom(), $urandom(), 1'($urandom_range(0, 1)));
      applyStimulus($urandom_range(0, 6), $urandom(), w);
    end
    while (pend != 2'b00) applyStimulus($urandom_range(0, 6), $urandom(), w);

    repeat (5) @(negedge clk);
    checks++;
    if (gntQ.size() != 0 || cplQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got grants=%0d completions=%0d pending required 0", gntQ.size(), cplQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of slave-wait cycles before an error completion; legal range is 1-255.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have ports m0_req_i/m1_req_i, input, 1 bit each: master request (m0 = core dbus, m1 = debug/DMA master).
REQ-007 The block SHALL have ports m0_addr_i/m1_addr_i, input, ADDR_W bits each: master address.
REQ-008 The block SHALL have ports m0_wdata_i/m1_wdata_i, input, DATA_W bits each: master write data.
REQ-009 The block SHALL have ports m0_w_en_i/m1_w_en_i, input, 1 bit each: write (1) or read (0).
REQ-010 The block SHALL have ports m0_ack_o/m1_ack_o, output, 1 bit each: master completion strobe.
REQ-011 The block SHALL have ports m0_rdata_o/m1_rdata_o, output, DATA_W bits each: master read data.
REQ-012 The block SHALL have ports m0_err_o/m1_err_o, output, 1 bit each: timeout flag, valid with ack.
REQ-013 The block SHALL have slave-side outputs s_req_o (1 bit), s_addr_o (ADDR_W), s_wdata_o (DATA_W) and s_w_en_o (1 bit), all toward the peripheral bus.
REQ-014 The block SHALL have slave-side inputs s_ack_i (1 bit) and s_rdata_i (DATA_W bits), both from the peripheral bus.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, GNT0 and GNT1.
REQ-016 In IDLE with a single requester, the FSM SHALL move to that requester's GNT state on the next edge.
REQ-017 In IDLE with both requesting, the FSM SHALL grant the master not granted last (round-robin); after reset, m0 SHALL be favoured.
REQ-018 The last-grant flop SHALL update on entry to GNT0 or GNT1.
REQ-019 In GNTx, s_req_o SHALL be 1 and s_addr_o, s_wdata_o and s_w_en_o SHALL mux from master x.
REQ-020 In IDLE, s_req_o SHALL be 0 and s_addr_o, s_wdata_o and s_w_en_o SHALL be 0.
REQ-021 In GNTx, mx_ack_o SHALL equal s_ack_i combinationally and mx_rdata_o SHALL equal s_rdata_i.
REQ-022 The non-granted master SHALL see ack=0, rdata=0 and err=0.
REQ-023 One grant SHALL equal one transaction; on s_ack_i=1 in GNTx, the FSM SHALL return to IDLE on the next edge.
REQ-024 The minimum spacing between two slave requests SHALL therefore be one IDLE cycle.
REQ-025 Latency SHALL be one cycle from request sampled in IDLE to s_req_o=1, plus the slave wait.
REQ-026 An 8-bit wait counter SHALL clear on entry to GNTx and increment each GNTx cycle without s_ack_i.
REQ-027 When the wait counter equals TIMEOUT and s_ack_i=0, the block SHALL assert mx_ack_o=1, mx_err_o=1 and mx_rdata_o=0 for that cycle, then go to IDLE.
REQ-028 When s_ack_i=1 in the same cycle that the counter reaches TIMEOUT, the block SHALL give a normal completion with err=0 (ack wins).
REQ-029 The block SHALL treat mX_req_i as level-sensitive; masters hold request and payload until ack, and no request is latched by the block.
REQ-030 In GNTx, the block SHALL ignore the other master's request until return to IDLE, so there is no preemption.
REQ-031 A master dropping its request while in GNTx SHALL NOT abort the transaction; the FSM SHALL remain in GNTx until ack or timeout.
REQ-032 An s_ack_i arriving in IDLE SHALL be ignored, producing no master ack.

Reset
REQ-033 When rst_n=0, the block SHALL asynchronously force the FSM to IDLE, the last-grant flop to 1 (so m0 wins first), and the wait counter to 0.
REQ-034 During reset, all outputs SHALL be 0.
REQ-035 Reset asserted mid-transaction SHALL drop s_req_o immediately with no master ack issued.
REQ-036 Release SHALL be synchronous to clk, with the first grant possible on the second edge after deassertion.

Verification
REQ-037 The bench SHALL cover: m0 read at addr 0x0000_0010, slave acks after 3 cycles with 0xDEAD_BEEF -> s_req_o high 4 cycles, m0_ack_o one cycle, m0_rdata_o=0xDEAD_BEEF, m0_err_o=0.
REQ-038 The bench SHALL cover: both request continuously from reset, slave acks every request in 1 cycle -> grant order m0,m1,m0,m1; the m1 write payload appears on s_wdata_o only in GNT1.
REQ-039 The bench SHALL cover: TIMEOUT=4, m1 request, slave never acks -> m1_ack_o=1 and m1_err_o=1 in the 5th GNT1 cycle, then IDLE.
REQ-040 The bench SHALL cover: TIMEOUT=4, s_ack_i in exactly that 5th cycle -> m1_ack_o=1, m1_err_o=0, rdata passed through.
REQ-041 The bench SHALL cover: rst_n pulled low in the 2nd cycle of GNT0 -> s_req_o=0 the same cycle; after release, m0 and m1 both requesting -> m0 granted first.
REQ-042 The bench SHALL cover: stray s_ack_i pulses while in IDLE -> no mX_ack_o asserted.
